// File: rtl/px_ss_pkg.sv
// Shared types and constants for the pixel/line skip configuration calculator.
package px_ss_pkg;

    localparam int unsigned PX_SS_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DIV_PX,
        ST_DIV_LN,
        ST_UPDATE
    } px_ss_state_e;

    // Captured request: source and target frame sizes.
    typedef struct packed {
        logic [PX_SS_W-1:0] in_w;
        logic [PX_SS_W-1:0] in_h;
        logic [PX_SS_W-1:0] out_w;
        logic [PX_SS_W-1:0] out_h;
    } px_ss_size_t;

    // A request is unusable if it upscales or asks for an empty frame.
    function automatic logic size_bad(input px_ss_size_t s);
        return (s.out_w > s.in_w) || (s.out_h > s.in_h) ||
               (s.out_w == '0) || (s.out_h == '0);
    endfunction

endpackage

// File: rtl/px_ss_if.sv
// Skip-parameter bundle driven by the calculator towards the scaler.
interface px_ss_if;

    logic [px_ss_pkg::PX_SS_W-1:0] px_to_skip;
    logic [px_ss_pkg::PX_SS_W-1:0] px_skip_interval;
    logic [px_ss_pkg::PX_SS_W-1:0] add_px_skip_interval;
    logic [px_ss_pkg::PX_SS_W-1:0] ln_to_skip;
    logic [px_ss_pkg::PX_SS_W-1:0] ln_skip_interval;
    logic [px_ss_pkg::PX_SS_W-1:0] add_ln_skip_interval;

    modport master (
        output px_to_skip, px_skip_interval, add_px_skip_interval,
        output ln_to_skip, ln_skip_interval, add_ln_skip_interval
    );

    modport slave (
        input px_to_skip, px_skip_interval, add_px_skip_interval,
        input ln_to_skip, ln_skip_interval, add_ln_skip_interval
    );

endinterface

// File: rtl/px_ss_serial_div.sv
// Restoring serial divider: one quotient bit per cycle, the first bit is
// resolved on the start edge so a division occupies exactly PX_SS_W edges.
module px_ss_serial_div
    import px_ss_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PX_SS_W-1:0] dividend,
    input  logic [PX_SS_W-1:0] divisor,
    output logic [PX_SS_W-1:0] quotient,
    output logic [PX_SS_W-1:0] remainder,
    output logic               done
);

    localparam int unsigned CNT_W = $clog2(PX_SS_W);

    logic [PX_SS_W-1:0] rem_q, quo_q, div_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               run_q;

    logic [PX_SS_W-1:0] src_rem, src_quo, src_div;
    logic [PX_SS_W:0]   trial;
    logic [PX_SS_W-1:0] nxt_rem, nxt_quo;

    // One restoring step, fed from the operands on start, else from state.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_div = start ? divisor : div_q;
        trial   = {src_rem, src_quo[PX_SS_W-1]} - {1'b0, src_div};
        nxt_rem = {src_rem[PX_SS_W-2:0], src_quo[PX_SS_W-1]};
        nxt_quo = {src_quo[PX_SS_W-2:0], 1'b0};
        if (!trial[PX_SS_W]) begin
            nxt_rem = trial[PX_SS_W-1:0];
            nxt_quo = {src_quo[PX_SS_W-2:0], 1'b1};
        end
    end

    // Iteration state and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q <= nxt_rem;
                quo_q <= nxt_quo;
                div_q <= divisor;
                cnt_q <= CNT_W'(1);
                run_q <= 1'b1;
            end else if (run_q) begin
                rem_q <= nxt_rem;
                quo_q <= nxt_quo;
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == '1) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/px_ss_cfg_calc.sv
// Computes pixel/line skip parameters for a downscale request and applies
// all six together once both divisions have finished.
module px_ss_cfg_calc
    import px_ss_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [PX_SS_W-1:0] in_width_i,
    input  logic [PX_SS_W-1:0] in_height_i,
    input  logic [PX_SS_W-1:0] out_width_i,
    input  logic [PX_SS_W-1:0] out_height_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    px_ss_if.master            px_ss
);

    px_ss_state_e       state_q, state_d;
    px_ss_size_t        size_q;
    logic               chk_ph_q, bad_q;
    logic [PX_SS_W-1:0] px_quo_q, px_rem_q;

    logic               accept_c;
    logic [PX_SS_W-1:0] px_skip_c, ln_skip_c;
    logic               div_start_c;
    logic [PX_SS_W-1:0] div_dividend_c, div_divisor_c;
    logic [PX_SS_W-1:0] div_quo, div_rem;
    logic               div_done;

    // A start coinciding with a done/err pulse is dropped.
    assign accept_c  = (state_q == ST_IDLE) && start_i && !done_o && !err_o;
    assign px_skip_c = size_q.in_w - size_q.out_w;
    assign ln_skip_c = size_q.in_h - size_q.out_h;

    px_ss_serial_div u_div (
        .clk       (clk_i),
        .rst       (rst_i),
        .start     (div_start_c),
        .dividend  (div_dividend_c),
        .divisor   (div_divisor_c),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    // Next-state and divider launch; CHECK spends one cycle registering the
    // size comparison and acts on it in the second.
    always_comb begin
        state_d        = state_q;
        div_start_c    = 1'b0;
        div_dividend_c = size_q.out_w;
        div_divisor_c  = px_skip_c;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (chk_ph_q) begin
                    if (bad_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_DIV_PX;
                        div_start_c = 1'b1;
                    end
                end
            end
            ST_DIV_PX: begin
                div_dividend_c = size_q.out_h;
                div_divisor_c  = ln_skip_c;
                if (div_done) begin
                    state_d     = ST_DIV_LN;
                    div_start_c = 1'b1;
                end
            end
            ST_DIV_LN: begin
                if (div_done) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Request capture, size check and pixel-division result holding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            size_q   <= '0;
            chk_ph_q <= 1'b0;
            bad_q    <= 1'b0;
            px_quo_q <= '0;
            px_rem_q <= '0;
        end else begin
            if (accept_c) begin
                size_q <= '{in_w: in_width_i, in_h: in_height_i,
                            out_w: out_width_i, out_h: out_height_i};
            end
            chk_ph_q <= (state_q == ST_CHECK) && !chk_ph_q;
            if ((state_q == ST_CHECK) && !chk_ph_q) bad_q <= size_bad(size_q);
            if ((state_q == ST_DIV_PX) && div_done) begin
                px_quo_q <= div_quo;
                px_rem_q <= div_rem;
            end
        end
    end

    // Status outputs; busy drops on the same edge that raises done/err.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_o <= 1'b0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            busy_o <= (state_q != ST_IDLE) && (state_d != ST_IDLE);
            done_o <= (state_q == ST_UPDATE);
            err_o  <= (state_q == ST_CHECK) && chk_ph_q && bad_q;
        end
    end

    // Apply all six skip parameters at once; a zero skip count means no skipping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            px_ss.px_to_skip           <= '0;
            px_ss.px_skip_interval     <= '0;
            px_ss.add_px_skip_interval <= '0;
            px_ss.ln_to_skip           <= '0;
            px_ss.ln_skip_interval     <= '0;
            px_ss.add_ln_skip_interval <= '0;
        end else if (state_q == ST_UPDATE) begin
            px_ss.px_to_skip           <= px_skip_c;
            px_ss.px_skip_interval     <= (px_skip_c == '0) ? '0 : px_quo_q;
            px_ss.add_px_skip_interval <= (px_skip_c == '0) ? '0 : px_rem_q;
            px_ss.ln_to_skip           <= ln_skip_c;
            px_ss.ln_skip_interval     <= (ln_skip_c == '0) ? '0 : div_quo;
            px_ss.add_ln_skip_interval <= (ln_skip_c == '0) ? '0 : div_rem;
        end
    end

endmodule

// File: tb/tb_px_ss_cfg_calc.sv
// Bench for px_ss_cfg_calc: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_px_ss_cfg_calc;

    typedef logic [15:0] w16_t;

    logic clk = 1'b0;
    logic rst, start;
    w16_t iw, ih, ow, oh;
    logic busy, done, err;

    px_ss_if u_px_ss ();

    px_ss_cfg_calc dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .in_width_i   (iw),
        .in_height_i  (ih),
        .out_width_i  (ow),
        .out_height_i (oh),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .px_ss        (u_px_ss)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int ecnt = 0;

    task automatic chk(input string nm, input w16_t act, input w16_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d expected %0d", nm, ecnt, act, exp);
    endtask

    // Skip parameters for one dimension, straight from the definitions.
    function automatic void calc(input w16_t i, input w16_t o,
                                 output w16_t sk, output w16_t iv, output w16_t ad);
        sk = i - o;
        if (sk == 16'd0) begin
            iv = 16'd0;
            ad = 16'd0;
        end else begin
            iv = o / sk;
            ad = o % sk;
        end
    endfunction

    // Reference model: a request is either idle or pending until a known edge.
    bit   m_pend, m_err_pend, m_busy, m_done, m_err, m_last;
    int   m_fin;
    w16_t m_v[6];
    w16_t m_pv[6];

    always @(posedge clk) begin
        ecnt++;
        m_last = m_done || m_err;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            m_pend = 1'b0;
            m_busy = 1'b0;
            foreach (m_v[k]) m_v[k] = 16'd0;
        end else if (m_pend && ecnt == m_fin) begin
            if (m_err_pend) m_err = 1'b1;
            else begin
                m_v    = m_pv;
                m_done = 1'b1;
            end
            m_pend = 1'b0;
            m_busy = 1'b0;
        end else if (!m_pend && !m_last && start) begin
            m_pend     = 1'b1;
            m_busy     = 1'b0;
            m_err_pend = (ow > iw) || (oh > ih) || (ow == 16'd0) || (oh == 16'd0);
            m_fin      = ecnt + (m_err_pend ? 2 : 35);
            calc(iw, ow, m_pv[0], m_pv[1], m_pv[2]);
            calc(ih, oh, m_pv[3], m_pv[4], m_pv[5]);
        end else begin
            m_busy = m_pend;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (ecnt > 0) begin
            chk("busy", 16'(busy), 16'(m_busy));
            chk("done", 16'(done), 16'(m_done));
            chk("err",  16'(err),  16'(m_err));
            chk("px_to_skip",           u_px_ss.px_to_skip,           m_v[0]);
            chk("px_skip_interval",     u_px_ss.px_skip_interval,     m_v[1]);
            chk("add_px_skip_interval", u_px_ss.add_px_skip_interval, m_v[2]);
            chk("ln_to_skip",           u_px_ss.ln_to_skip,           m_v[3]);
            chk("ln_skip_interval",     u_px_ss.ln_skip_interval,     m_v[4]);
            chk("add_ln_skip_interval", u_px_ss.add_ln_skip_interval, m_v[5]);
        end
    end

    task automatic chk6(input string tag, input int a, input int b, input int c,
                        input int d, input int e, input int f);
        chk({tag, "_px_to_skip"}, u_px_ss.px_to_skip,           16'(a));
        chk({tag, "_px_int"},     u_px_ss.px_skip_interval,     16'(b));
        chk({tag, "_px_add"},     u_px_ss.add_px_skip_interval, 16'(c));
        chk({tag, "_ln_to_skip"}, u_px_ss.ln_to_skip,           16'(d));
        chk({tag, "_ln_int"},     u_px_ss.ln_skip_interval,     16'(e));
        chk({tag, "_ln_add"},     u_px_ss.add_ln_skip_interval, 16'(f));
    endtask

    // One-cycle start pulse; inputs are scrambled afterwards to prove capture.
    task automatic drive_start(input int a, input int b, input int c, input int d,
                               output int s_e);
        @(negedge clk);
        iw = 16'(a); ih = 16'(b); ow = 16'(c); oh = 16'(d);
        start = 1'b1;
        s_e = ecnt + 1;
        @(negedge clk);
        start = 1'b0;
        iw = 16'($urandom); ih = 16'($urandom); ow = 16'($urandom); oh = 16'($urandom);
    endtask

    task automatic wait_pulse(input string tag, output bit got, output int p_e);
        got = 1'b0;
        p_e = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done || err) begin
                got = 1'b1;
                p_e = ecnt;
                break;
            end
        end
        chk({tag, "_pulse_seen"}, 16'(got), 16'd1);
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done || err) n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int   s, p, n;
        bit   got;
        w16_t sk, iv, ad;
        int   a, b, c, d, mode;

        rst = 1'b1; start = 1'b0;
        iw = 16'd0; ih = 16'd0; ow = 16'd0; oh = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_err",  16'(err),  16'd0);
        chk6("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Pin the model on hand-worked values.
        calc(16'd1920, 16'd1366, sk, iv, ad);
        chk("model_px_sk", sk, 16'd554);
        chk("model_px_iv", iv, 16'd2);
        chk("model_px_ad", ad, 16'd258);
        calc(16'd480, 16'd480, sk, iv, ad);
        chk("model_eq_iv", iv, 16'd0);

        // 1920x1080 -> 1280x720
        drive_start(1920, 1080, 1280, 720, s);
        wait_pulse("hd720", got, p);
        chk("hd720_lat", 16'(p - s), 16'd35);
        chk("hd720_done", 16'(done), 16'd1);
        chk6("hd720", 640, 2, 0, 360, 2, 0);

        // Identity size: no skipping, latency unchanged
        drive_start(640, 480, 640, 480, s);
        wait_pulse("ident", got, p);
        chk("ident_lat", 16'(p - s), 16'd35);
        chk6("ident", 0, 0, 0, 0, 0, 0);

        // 1920x1080 -> 1366x768
        drive_start(1920, 1080, 1366, 768, s);
        wait_pulse("wxga", got, p);
        chk("wxga_lat", 16'(p - s), 16'd35);
        chk6("wxga", 554, 2, 258, 312, 2, 144);

        // Upscale request rejected, outputs held
        drive_start(1920, 1080, 2000, 720, s);
        wait_pulse("upscale", got, p);
        chk("upscale_lat", 16'(p - s), 16'd2);
        chk("upscale_err", 16'(err), 16'd1);
        chk("upscale_busy", 16'(busy), 16'd0);
        count_pulses(40, n);
        chk("upscale_no_done", 16'(n), 16'd0);
        chk6("upscale", 554, 2, 258, 312, 2, 144);

        // Second start while busy is dropped
        drive_start(1920, 1080, 1280, 720, s);
        while (ecnt < s + 9) @(negedge clk);
        iw = 16'd1920; ih = 16'd1080; ow = 16'd1366; oh = 16'd768;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_pulse("busy_start", got, p);
        chk("busy_start_lat", 16'(p - s), 16'd35);
        chk6("busy_start", 640, 2, 0, 360, 2, 0);
        count_pulses(40, n);
        chk("busy_start_single", 16'(n), 16'd0);

        // Start held across the done cycle is taken one cycle later
        drive_start(1920, 1080, 1366, 768, s);
        wait_pulse("back2back_a", got, p);
        iw = 16'd1920; ih = 16'd1080; ow = 16'd1280; oh = 16'd720;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_pulse("back2back_b", got, n);
        chk("back2back_lat", 16'(n - (p + 2)), 16'd35);
        chk6("back2back", 640, 2, 0, 360, 2, 0);

        // Reset mid-computation aborts silently
        drive_start(1920, 1080, 1366, 768, s);
        while (ecnt < s + 19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 16'(busy), 16'd0);
        chk6("abort", 0, 0, 0, 0, 0, 0);
        count_pulses(40, n);
        chk("abort_no_pulse", 16'(n), 16'd0);
        drive_start(1920, 1080, 1366, 768, s);
        wait_pulse("after_abort", got, p);
        chk("after_abort_lat", 16'(p - s), 16'd35);
        chk6("after_abort", 554, 2, 258, 312, 2, 144);

        // Random traffic against the model
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            a = ($urandom % 4 == 0) ? int'($urandom_range(40, 0)) : int'($urandom_range(65535, 1));
            b = ($urandom % 4 == 0) ? int'($urandom_range(40, 0)) : int'($urandom_range(65535, 1));
            mode = int'($urandom % 10);
            case (mode)
                0:       begin c = a; d = b; end
                1:       begin c = 0; d = int'($urandom_range(b, 0)); end
                2:       begin c = (a < 65535) ? a + 1 : a; d = int'($urandom_range(b, 0)); end
                default: begin c = int'($urandom_range(a, 0)); d = int'($urandom_range(b, 0)); end
            endcase
            iw = 16'(a); ih = 16'(b); ow = 16'(c); oh = 16'(d);
            start = ($urandom % 6 == 0);
            rst   = ($urandom % 700 == 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (50) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
